// File: rtl/mult_sequencer.sv
// mult_sequencer: sequences one operand pair into an external byte-serial signed multiplier
// and returns its 16-bit product.
//
// Ports:
//   clk, rst_b                    clock, asynchronous active-low reset
//   in_valid/in_ready/in_m/in_q   upstream operand handshake (two's complement bytes)
//   bgn, ibus                     start pulse and operand bus to the multiplier
//   stop, obus                    done level and result bus from the multiplier
//   out_valid/out_ready           downstream product handshake
//   out_prod, err                 signed product and timeout flag for the held result
//
// Flow: IDLE -> START -> LD_M -> LD_Q -> RUN -> DONE -> IDLE. In RUN, a rising edge on stop
// completes the product. If no edge arrives within TIMEOUT cycles, a zero product is returned
// with err set. All outputs are registered.

module mult_sequencer #(
  parameter int unsigned TIMEOUT = 64
) (
  input  logic        clk,
  input  logic        rst_b,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [7:0]  in_m,
  input  logic [7:0]  in_q,
  output logic        bgn,
  output logic [7:0]  ibus,
  input  logic        stop,
  input  logic [7:0]  obus,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [15:0] out_prod,
  output logic        err
);

  typedef enum logic [2:0] {
    StIdle  = 3'd0,
    StStart = 3'd1,
    StLdM   = 3'd2,
    StLdQ   = 3'd3,
    StRun   = 3'd4,
    StDone  = 3'd5
  } state_e;

  // Last counter value in RUN; reaching it without a stop edge declares a timeout.
  localparam logic [7:0] CntLast = 8'(TIMEOUT - 1);

  state_e      state_q;
  logic [7:0]  m_q;
  logic [7:0]  q_q;
  logic [7:0]  cnt_q;
  logic [7:0]  obus_prev_q;  // obus one cycle ago: carries the product high byte
  logic        stop_prev_q;  // stop one cycle ago: used for edge detection
  logic        in_ready_q;
  logic        bgn_q;
  logic [7:0]  ibus_q;
  logic        out_valid_q;
  logic [15:0] prod_q;
  logic        err_q;
  logic        stop_rise;

  // A stop level already high on RUN entry does not count as an edge.
  assign stop_rise = stop & ~stop_prev_q;

  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      state_q     <= StIdle;
      m_q         <= 8'h00;
      q_q         <= 8'h00;
      cnt_q       <= 8'h00;
      obus_prev_q <= 8'h00;
      stop_prev_q <= 1'b0;
      in_ready_q  <= 1'b1;
      bgn_q       <= 1'b0;
      ibus_q      <= 8'h00;
      out_valid_q <= 1'b0;
      prod_q      <= 16'h0000;
      err_q       <= 1'b0;
    end else begin
      obus_prev_q <= obus;
      stop_prev_q <= stop;
      case (state_q)
        StIdle: begin
          if (in_valid) begin
            m_q        <= in_m;
            q_q        <= in_q;
            in_ready_q <= 1'b0;
            bgn_q      <= 1'b1;
            ibus_q     <= in_m;
            state_q    <= StStart;
          end
        end
        StStart: begin
          bgn_q   <= 1'b0;
          ibus_q  <= m_q;
          state_q <= StLdM;
        end
        StLdM: begin
          ibus_q  <= q_q;
          state_q <= StLdQ;
        end
        StLdQ: begin
          ibus_q  <= 8'h00;
          cnt_q   <= 8'h00;
          state_q <= StRun;
        end
        StRun: begin
          // The stop edge is checked first so that it wins over a coincident timeout.
          if (stop_rise) begin
            prod_q      <= {obus_prev_q, obus};
            err_q       <= 1'b0;
            out_valid_q <= 1'b1;
            state_q     <= StDone;
          end else if (cnt_q == CntLast) begin
            prod_q      <= 16'h0000;
            err_q       <= 1'b1;
            out_valid_q <= 1'b1;
            state_q     <= StDone;
          end else begin
            cnt_q <= cnt_q + 8'd1;
          end
        end
        StDone: begin
          if (out_ready) begin
            out_valid_q <= 1'b0;
            in_ready_q  <= 1'b1;
            state_q     <= StIdle;
          end
        end
        default: begin
          out_valid_q <= 1'b0;
          in_ready_q  <= 1'b1;
          bgn_q       <= 1'b0;
          ibus_q      <= 8'h00;
          state_q     <= StIdle;
        end
      endcase
    end
  end

  assign in_ready  = in_ready_q;
  assign bgn       = bgn_q;
  assign ibus      = ibus_q;
  assign out_valid = out_valid_q;
  assign out_prod  = prod_q;
  assign err       = err_q;

endmodule

// File: doc/mult_sequencer.md
MULT_SEQUENCER -- requirements
Module: mult_sequencer

Interface
REQ-001 The block SHALL have parameter TIMEOUT, default 64: maximum cycles spent in RUN before an error is declared.
REQ-002 clk  input  1  single clock; all flops rise-edge triggered.
REQ-003 rst_b  input  1  reset, asynchronous, active-low.
REQ-004 in_valid  input  1  operand pair offered by upstream.
REQ-005 in_ready  output  1  sequencer can accept an operand pair.
REQ-006 in_m  input  8  multiplicand, two's complement.
REQ-007 in_q  input  8  multiplier, two's complement.
REQ-008 bgn  output  1  start pulse to the multiplier.
REQ-009 ibus  output  8  operand bus to the multiplier.
REQ-010 stop  input  1  multiplier done level.
REQ-011 obus  input  8  multiplier result bus.
REQ-012 out_valid  output  1  product available.
REQ-013 out_ready  input  1  downstream accepts product.
REQ-014 out_prod  output  16  signed product {high byte, low byte}.
REQ-015 err  output  1  timeout flag for the current result.

Function
REQ-016 The FSM SHALL have states IDLE, START, LD_M, LD_Q, RUN, DONE, encoded in 3 bits.
REQ-017 IDLE: in_ready=1; on in_valid=1, in_m and in_q latch into m_reg and q_reg; next state is START.
REQ-018 in_ready SHALL be 0 in every state except IDLE; in_valid outside IDLE is ignored and no operands latch.
REQ-019 START: bgn=1 and ibus=m_reg for exactly one cycle; next state is LD_M.
REQ-020 LD_M: ibus=m_reg; next state is LD_Q.
REQ-021 LD_Q: ibus=q_reg; next state is RUN.
REQ-022 In IDLE, RUN and DONE, ibus SHALL be 8'h00 and bgn SHALL be 0.
REQ-023 obus SHALL be registered every cycle into obus_d, and stop into stop_d.
REQ-024 RUN: a stop rising edge (stop=1, stop_d=0) SHALL capture out_prod={obus_d, obus} and clear err; next state is DONE.
REQ-025 A stop level already high on RUN entry SHALL NOT count; only a rising edge completes.
REQ-026 An 8-bit cycle counter SHALL clear on RUN entry and increment each RUN cycle.
REQ-027 If the counter reaches TIMEOUT-1 without a stop edge, the block SHALL load out_prod=16'h0000 and err=1; next state is DONE.
REQ-028 If a stop edge and the timeout coincide in the same cycle, the stop edge SHALL win (err=0).
REQ-029 DONE: out_valid=1; out_prod and err SHALL stay stable until out_ready=1; next state is IDLE.
REQ-030 With out_valid=1 and out_ready=0, the FSM SHALL hold in DONE indefinitely.
REQ-031 Minimum latency SHALL be 5 cycles from operand acceptance to out_valid, given a stop edge on the first RUN cycle.
REQ-032 Throughput SHALL be one product per transaction; there is no operand buffering beyond m_reg and q_reg.

Reset
REQ-033 While rst_b=0, the following SHALL hold:
- state=IDLE
- in_ready=1, bgn=0, ibus=0
- out_valid=0, out_prod=0, err=0
- m_reg=0, q_reg=0, counter=0, obus_d=0, stop_d=0
REQ-034 Reset asserted mid-operation in any state SHALL abort the transaction with no output; the next in_valid after release starts a fresh transaction.

Verification
REQ-035 Scenario: in_m=3, in_q=5; the multiplier model drives obus 8'h00 then 8'h0F and raises stop -> bgn pulses one cycle with ibus 3, 3, 5 over consecutive cycles; out_prod=16'h000F; err=0.
REQ-036 Scenario: in_m=8'hF9 (-7), in_q=3; model returns 8'hFF then 8'hEB -> out_prod=16'hFFEB; err=0.
REQ-037 Scenario: out_ready held 0 for 10 cycles after out_valid -> out_valid and out_prod stable for all 10 cycles; in_ready=0 throughout; IDLE entered one cycle after out_ready=1.
REQ-038 Scenario: stop never rises, TIMEOUT=64 -> out_valid after 64 RUN cycles; out_prod=0; err=1; the next good transaction clears err.
REQ-039 Scenario: stop already high on RUN entry, then falls and rises 3 cycles later -> the product is captured only on that later rising edge.
REQ-040 Scenario: rst_b pulsed low in RUN -> all outputs immediately at reset values; a following transaction with in_m=2, in_q=2 yields 16'h0004.
